// File: rtl/tmc_spi_responder.sv
// tmc_spi_responder: emulates one TMC5130A on an SPI mode-3 daisy chain.
// Each datagram is 40 bits. The chip answers with a status byte plus the read data
// requested in the previous frame, and passes longer frames straight through.
// Optional feature macro: TMCRESP_RDMASK_EN adds RD_MASK. Addresses whose mask bit
// is 0 read back as zero over SPI.
module tmc_spi_responder #(
   parameter int          SYNC_STAGES  = 2,
   parameter logic [7:0]  RESET_STATUS = 8'h00
`ifdef TMCRESP_RDMASK_EN
   ,
   parameter logic [127:0] RD_MASK     = '1
`endif
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sclk,
   input  logic        csn,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic [7:0]  status_i,
   input  logic        host_we,
   input  logic [6:0]  host_addr,
   input  logic [31:0] host_wdata,
   output logic [31:0] host_rdata,
   output logic        spi_wr,
   output logic [6:0]  spi_waddr,
   output logic [31:0] spi_wdata,
   output logic        frame_err
);

   typedef enum logic [1:0] {S_WAIT_HIGH, S_IDLE, S_SHIFT, S_COMMIT} state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_mosi_sync;
   logic        r_sclk_d, r_csn_d;
   logic        w_sclk_s, w_csn_s, w_mosi_s;
   logic        w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise;
   state_t      r_state, w_next;
   logic [7:0]  r_status_q;   // upper byte of the 40-bit shift register
   logic [31:0] r_sr_lo;
   logic [31:0] r_resp_q;
   logic [5:0]  r_bitcnt;
   logic        r_miso_q, r_miso_oe;
   logic        r_spi_wr, r_frame_err;
   logic [6:0]  r_spi_waddr;
   logic [31:0] r_spi_wdata, r_host_rdata;
   logic        r_clr_busy;
   logic [6:0]  r_clr_idx;
   logic [31:0] r_mem [128];
   logic [6:0]  w_cmd_addr;
   logic        w_commit_ok, w_spi_we;
   logic [31:0] w_rd_val;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_csn_fall  = ~w_csn_s & r_csn_d;
   assign w_csn_rise  = w_csn_s & ~r_csn_d;

   assign w_cmd_addr  = r_status_q[6:0];
   assign w_commit_ok = (r_state == S_COMMIT) && (r_bitcnt >= 6'd40);
   assign w_spi_we    = w_commit_ok && r_status_q[7];

`ifdef TMCRESP_RDMASK_EN
   assign w_rd_val = RD_MASK[w_cmd_addr] ? r_mem[w_cmd_addr] : 32'h0;
`else
   assign w_rd_val = r_mem[w_cmd_addr];
`endif

   // Synchronize SPI pins and keep one extra flop for edge detection.
   // csn resets low so that a frame already in progress at reset is never seen as a fresh falling edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_sclk_sync <= '1;
         r_csn_sync  <= '0;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b1;
         r_csn_d     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_sclk_d    <= w_sclk_s;
         r_csn_d     <= w_csn_s;
      end
   end

   // Sequence through all 128 entries after reset to clear the register file.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_clr_busy <= 1'b1;
         r_clr_idx  <= 7'd0;
      end else if (r_clr_busy) begin
         r_clr_idx <= r_clr_idx + 7'd1;
         if (r_clr_idx == 7'd127) r_clr_busy <= 1'b0;
      end
   end

   // Register file write ports. When the host and SPI hit the same address in one cycle, SPI wins.
   always_ff @(posedge clk) begin
      if (r_clr_busy) begin
         r_mem[r_clr_idx] <= 32'h0;
      end else begin
         if (host_we && !(w_spi_we && (host_addr == w_cmd_addr)))
            r_mem[host_addr] <= host_wdata;
         if (w_spi_we)
            r_mem[w_cmd_addr] <= r_sr_lo;
      end
   end

   // Registered host read port.
   always_ff @(posedge clk) begin
      if (!resetn) r_host_rdata <= 32'h0;
      else         r_host_rdata <= r_mem[host_addr];
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_WAIT_HIGH;
      else         r_state <= w_next;
   end

   // FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_WAIT_HIGH: if (w_csn_s)    w_next = S_IDLE;
         S_IDLE:      if (w_csn_fall) w_next = S_SHIFT;
         S_SHIFT:     if (w_csn_rise) w_next = S_COMMIT;
         S_COMMIT:                    w_next = S_IDLE;
         default:                     w_next = S_WAIT_HIGH;
      endcase
   end

   // Shift datapath, miso driver and commit actions.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_status_q  <= RESET_STATUS;
         r_sr_lo     <= 32'h0;
         r_resp_q    <= 32'h0;
         r_bitcnt    <= 6'd0;
         r_miso_q    <= 1'b1;
         r_miso_oe   <= 1'b0;
         r_spi_wr    <= 1'b0;
         r_frame_err <= 1'b0;
         r_spi_waddr <= 7'd0;
         r_spi_wdata <= 32'h0;
      end else begin
         r_spi_wr    <= 1'b0;
         r_frame_err <= 1'b0;
         r_miso_oe   <= ~w_csn_s;
         case (r_state)
            S_IDLE: begin
               if (w_csn_fall) begin
                  r_status_q <= status_i;
                  r_sr_lo    <= r_resp_q;
                  r_miso_q   <= status_i[7];
                  r_bitcnt   <= 6'd0;
               end
            end
            S_SHIFT: begin
               if (w_sclk_rise) begin
                  {r_status_q, r_sr_lo} <= {r_status_q[6:0], r_sr_lo, w_mosi_s};
                  if (r_bitcnt != 6'd63) r_bitcnt <= r_bitcnt + 6'd1;
               end
               if (w_sclk_fall) r_miso_q <= r_status_q[7];
            end
            S_COMMIT: begin
               if (r_bitcnt < 6'd40) begin
                  r_frame_err <= 1'b1;
               end else if (r_status_q[7]) begin
                  r_spi_wr    <= 1'b1;
                  r_spi_waddr <= w_cmd_addr;
                  r_spi_wdata <= r_sr_lo;
               end else begin
                  r_resp_q <= w_rd_val;
               end
            end
            default: ;
         endcase
      end
   end

   assign miso       = r_miso_q;
   assign miso_oe    = r_miso_oe;
   assign host_rdata = r_host_rdata;
   assign spi_wr     = r_spi_wr;
   assign spi_waddr  = r_spi_waddr;
   assign spi_wdata  = r_spi_wdata;
   assign frame_err  = r_frame_err;

endmodule
